key_led_ctrl: RTL

//   Parametrised successor to the lab combinational key->LED logic: N push keys are

---
 rtl/key_led_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/key_led_ctrl.sv
// key_led_ctrl
//   Synchronises and debounces N_KEYS raw push keys, drives one registered LED
//   per key (toggle on press, or follow the debounced level), and reports
//   one-cycle press/release pulses plus a wrapping count of accepted presses.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst            synchronous reset, active high
//   i_key            raw asynchronous key inputs
//   o_led            registered LED drive
//   o_key_state      debounced level per key, 1 = pressed
//   o_press_pulse    one-cycle pulse per key on an accepted press
//   o_release_pulse  one-cycle pulse per key on an accepted release
//   o_any_pressed    OR of o_key_state
//   o_press_count    accepted presses, modulo 2^CNT_W
//
// Per-key debounce FSM
//   state           | meaning
//   ST_RELEASED     | key accepted as released
//   ST_PRESS_WAIT   | pressed level seen, counting stable samples
//   ST_PRESSED      | key accepted as pressed
//   ST_RELEASE_WAIT | released level seen, counting stable samples
module key_led_ctrl #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int LED_MODE        = 0,
  parameter int CNT_W           = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_led,
  output logic [N_KEYS-1:0] o_key_state,
  output logic [N_KEYS-1:0] o_press_pulse,
  output logic [N_KEYS-1:0] o_release_pulse,
  output logic              o_any_pressed,
  output logic [CNT_W-1:0]  o_press_count
);

  localparam int                DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_p;

  state_t            r_state [N_KEYS];
  logic [DB_W-1:0]   r_cnt   [N_KEYS];

  logic [N_KEYS-1:0] r_led;
  logic [N_KEYS-1:0] r_key_state;
  logic [N_KEYS-1:0] r_press_pulse;
  logic [N_KEYS-1:0] r_release_pulse;
  logic [CNT_W-1:0]  r_press_count;

  logic [N_KEYS-1:0] w_press_set;
  logic [N_KEYS-1:0] w_release_set;
  logic [N_KEYS-1:0] w_key_state_nxt;
  logic [CNT_W-1:0]  w_press_inc;

  // Reset loads the released level so a key held through reset still has
  // to be seen as a fresh edge and debounced from scratch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= KEY_IDLE;
      r_sync2 <= KEY_IDLE;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // Acceptance decisions are needed combinationally so the pulse, the LED
  // toggle and the counter increment all land on the same edge.
  always_comb begin
    w_press_set   = '0;
    w_release_set = '0;
    w_press_inc   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_press_set[i]   = (r_state[i] == ST_PRESS_WAIT)   &&  w_p[i] && (r_cnt[i] == DB_LAST);
      w_release_set[i] = (r_state[i] == ST_RELEASE_WAIT) && !w_p[i] && (r_cnt[i] == DB_LAST);
      w_press_inc      = w_press_inc + CNT_W'(w_press_set[i]);
    end
    w_key_state_nxt = (r_key_state | w_press_set) & ~w_release_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_state[i] <= ST_RELEASED;
        r_cnt[i]   <= '0;
      end
      r_led           <= '0;
      r_key_state     <= '0;
      r_press_pulse   <= '0;
      r_release_pulse <= '0;
      r_press_count   <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        case (r_state[i])
          ST_RELEASED: begin
            if (w_p[i]) begin
              r_state[i] <= ST_PRESS_WAIT;
              r_cnt[i]   <= '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (!w_p[i]) begin
              r_state[i] <= ST_RELEASED;
            end else if (r_cnt[i] == DB_LAST) begin
              r_state[i] <= ST_PRESSED;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!w_p[i]) begin
              r_state[i] <= ST_RELEASE_WAIT;
              r_cnt[i]   <= '0;
            end
          end
          ST_RELEASE_WAIT: begin
            if (w_p[i]) begin
              r_state[i] <= ST_PRESSED;
            end else if (r_cnt[i] == DB_LAST) begin
              r_state[i] <= ST_RELEASED;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
          default: begin
            r_state[i] <= ST_RELEASED;
            r_cnt[i]   <= '0;
          end
        endcase
      end

      r_key_state     <= w_key_state_nxt;
      r_press_pulse   <= w_press_set;
      r_release_pulse <= w_release_set;
      r_press_count   <= r_press_count + w_press_inc;

      if (LED_MODE != 0) begin
        r_led <= w_key_state_nxt;
      end else begin
        r_led <= r_led ^ w_press_set;
      end
    end
  end

  assign o_led           = r_led;
  assign o_key_state     = r_key_state;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;
  assign o_any_pressed   = |r_key_state;
  assign o_press_count   = r_press_count;

endmodule
